// File: rtl/sort_result_streamer.sv
// ---------------------------------------------------------------------------
// sort_result_streamer
//
// Purpose: after the sorter has finished, drain the N sorted words from the
// sort memory in address order and present them on a valid/ready stream.
// While streaming, it checks that the sequence is non-decreasing (unsigned).
// The memory has a registered read port, so each word costs READ, CAP and
// SEND: the fetch, the capture and the handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle dump request, honoured only in IDLE
//   busy         high while the memory port belongs to this block
//   mem_read     memory read strobe, one cycle per word
//   mem_addr     memory read address (0 when not reading)
//   mem_data_out memory read data, valid the cycle after mem_read
//   out_valid    stream word valid
//   out_data     stream word
//   out_last     marks the word from address BASE_ADDR+N-1
//   out_ready    downstream accept
//   dump_done    one-cycle pulse after the last handshake
//   sorted_ok    ascending-order verdict, held until the next start
// ---------------------------------------------------------------------------
module sort_result_streamer #(
    parameter int N         = 10,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              dump_done,
    output logic              sorted_ok
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_CAP       = 3'd2,
        S_SEND      = 3'd3,
        S_DUMP_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST_IDX = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LP_BASE     = ADDR_W'(BASE_ADDR);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_prev;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_sorted_ok;
    logic                w_is_last;
    logic                w_handshake;

    assign w_is_last   = (r_idx == LP_LAST_IDX);
    assign w_handshake = (r_state == S_SEND) && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_next = S_READ;
            S_READ:      w_state_next = S_CAP;
            S_CAP:       w_state_next = S_SEND;
            S_SEND: begin
                if (w_handshake) begin
                    w_state_next = w_is_last ? S_DUMP_DONE : S_READ;
                end
            end
            S_DUMP_DONE: w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the state so that reset clears them immediately
    always_comb begin
        busy      = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        dump_done = 1'b0;
        case (r_state)
            S_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = LP_BASE + r_idx;
            end
            S_CAP: begin
                busy = 1'b1;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = w_is_last;
            end
            S_DUMP_DONE: begin
                busy      = 1'b1;
                dump_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: word index, captured word and the running order check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_prev      <= '0;
            r_out_data  <= '0;
            r_sorted_ok <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    // The verdict of the previous dump survives until a new one begins
                    if (start) begin
                        r_sorted_ok <= 1'b1;
                    end
                end
                S_CAP: begin
                    r_out_data <= mem_data_out;
                    r_prev     <= mem_data_out;
                    // The first word has no predecessor to compare against
                    if ((r_idx != '0) && (mem_data_out < r_prev)) begin
                        r_sorted_ok <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (w_handshake && !w_is_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign sorted_ok = r_sorted_ok;

endmodule

// File: tb/tb_sort_result_streamer.sv
module tb_sort_result_streamer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        mem_read;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data_out;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        dump_done;
    logic        sorted_ok;

    logic [15:0] mem [0:1023];
    int          checks;
    int          errors;

    sort_result_streamer #(
        .N(10), .ADDR_W(10), .DATA_W(16), .BASE_ADDR(0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .dump_done    (dump_done),
        .sorted_ok    (sorted_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sort memory with registered read
    always @(posedge clk) begin
        if (mem_read) mem_data_out <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One dump: start is high for cycles c<hold and at c==repulse.
    // rst_word>0 asserts reset while that word is being offered.
    task automatic run_dump(input string name, input int ready_mode, input int hold,
                            input int repulse, input int rst_word, input logic exp_sorted);
        int          nrecv;
        int          nreads;
        int          nstall;
        int          nbusy;
        logic        got_done;
        logic        prev_stall;
        logic        prev_mr;
        logic [15:0] prev_d;
        logic        prev_l;
        logic [15:0] rxd [0:15];
        logic        rxl [0:15];
        nrecv = 0; nreads = 0; nstall = 0; nbusy = 0;
        got_done = 1'b0; prev_stall = 1'b0; prev_mr = 1'b0; prev_d = '0; prev_l = 1'b0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            @(posedge clk); #1;
            start     = (c < hold) || (c == repulse);
            out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c == 0) chk({name, "_busy_c0"}, 32'(busy), 32'd0);
            if (c == 1) chk({name, "_busy_c1"}, 32'(busy), 32'd1);
            if (c == 2) chk({name, "_valid_c2"}, 32'(out_valid), 32'd0);
            if (c == 3) chk({name, "_valid_c3"}, 32'(out_valid), 32'd1);
            if (busy) nbusy++;
            if (mem_read) begin
                chk($sformatf("%s_addr%0d", name, nreads), 32'(mem_addr), 32'(nreads));
                if (prev_mr) chk({name, "_mem_read_width"}, 32'(prev_mr), 32'd0);
                nreads++;
            end
            prev_mr = mem_read;
            if (prev_stall) begin
                chk({name, "_stall_valid"}, 32'(out_valid), 32'd1);
                chk({name, "_stall_data"}, 32'(out_data), 32'(prev_d));
                chk({name, "_stall_last"}, 32'(out_last), 32'(prev_l));
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
            if (prev_stall) nstall++;
            if (rst_word > 0 && nrecv == rst_word - 1 && out_valid) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                chk({name, "_rst_busy"}, 32'(busy), 32'd0);
                chk({name, "_rst_valid"}, 32'(out_valid), 32'd0);
                chk({name, "_rst_data"}, 32'(out_data), 32'd0);
                chk({name, "_rst_flags"}, 32'({mem_read, out_last, dump_done, sorted_ok}), 32'd0);
                chk({name, "_rst_addr"}, 32'(mem_addr), 32'd0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk($sformatf("%s_post_rst%0d", name, k), 32'({busy, dump_done}), 32'd0);
                end
                return;
            end
            if (out_valid && out_ready) begin
                if (nrecv < 16) begin
                    rxd[nrecv] = out_data;
                    rxl[nrecv] = out_last;
                end
                nrecv++;
            end
            if (dump_done) begin
                got_done = 1'b1;
                chk({name, "_sorted_ok"}, 32'(sorted_ok), 32'(exp_sorted));
                chk({name, "_busy_at_done"}, 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 32'(got_done), 32'd1);
        chk({name, "_nwords"}, 32'(nrecv), 32'd10);
        chk({name, "_nreads"}, 32'(nreads), 32'd10);
        chk({name, "_busy_cycles"}, 32'(nbusy), 32'(31 + nstall));
        for (int i = 0; i < 10 && i < nrecv; i++) begin
            chk($sformatf("%s_word%0d", name, i), 32'(rxd[i]), 32'(mem[i]));
            chk($sformatf("%s_last%0d", name, i), 32'(rxl[i]), 32'(i == 9));
        end
        $display("dump %s words=%0d reads=%0d stalls=%0d busy_cycles=%0d sorted_ok=%0b",
                 name, nrecv, nreads, nstall, nbusy, sorted_ok);
    endtask

    task automatic load_ascending();
        for (int i = 0; i < 10; i++) mem[i] = 16'(i + 1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_outputs", 32'({mem_read, out_valid, out_last, dump_done, sorted_ok}), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ascending contents, ready always high
        load_ascending();
        run_dump("asc", 0, 1, -1, 0, 1'b1);

        // Unsorted contents; start also raised during the DUMP_DONE cycle (c==31)
        mem[0] = 16'd5; mem[1] = 16'd3; mem[2] = 16'd8; mem[3] = 16'd1; mem[4] = 16'd9;
        mem[5] = 16'd2; mem[6] = 16'd7; mem[7] = 16'd4; mem[8] = 16'd6; mem[9] = 16'd0;
        run_dump("unsorted", 0, 1, 31, 0, 1'b0);
        @(negedge clk);
        chk("start_in_done_ignored", 32'(busy), 32'd0);

        // Ascending contents with random back-pressure
        load_ascending();
        run_dump("stall", 1, 1, -1, 0, 1'b1);

        // Ties plus top unsigned value at the last address
        for (int i = 0; i < 9; i++) mem[i] = 16'h7FFF;
        mem[9] = 16'hFFFF;
        run_dump("ties", 0, 1, -1, 0, 1'b1);

        // Reset during the 4th SEND, then a complete restart
        load_ascending();
        run_dump("abort", 0, 1, -1, 4, 1'b1);
        run_dump("restart", 0, 1, -1, 0, 1'b1);

        // Start held for 5 cycles and re-pulsed mid-dump
        run_dump("hold", 0, 5, 15, 0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("no_second_dump", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
